// File: rtl/mul8_seq.sv
// mul8_seq: 8x8 unsigned sequential shift-and-add multiplier built around a single adder8.
//   clk   in   1   rising-edge clock
//   rst_n in   1   asynchronous active-low reset
//   start in   1   request pulse, accepted only in IDLE
//   x     in   8   multiplicand, sampled with an accepted start
//   y     in   8   multiplier, sampled with an accepted start
//   p     out 16   registered product, updated on completion
//   busy  out  1   high while not IDLE
//   done  out  1   one-cycle completion pulse
// Optional: define MUL8_EARLY_EXIT_EN to finish zero-operand requests straight from IDLE.

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

module mul8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [16:0] work_q, work_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic [8:0]  sum;
    logic [16:0] added;
    logic [16:0] shifted;
    adder8 u_add (
        .a(work_q[15:8]),
        .b(mcand_q),
        .s(sum)
    );
    // The 9-bit sum lands in P[16:8] so the carry survives the following shift.
    assign added   = work_q[0] ? {sum, work_q[7:0]} : work_q;
    assign shifted = {1'b0, added[16:1]};
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = x;
                    work_d  = {9'h000, y};
                    cnt_d   = 3'd0;
                    state_d = RUN;
`ifdef MUL8_EARLY_EXIT_EN
                    if (x == 8'h00 || y == 8'h00) begin
                        state_d = DONE;
                        p_d     = 16'h0000;
                    end
`endif
                end
            end
            RUN: begin
                work_d = shifted;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    p_d     = shifted[15:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 8'h00;
            work_q  <= 17'h00000;
            cnt_q   <= 3'd0;
            p_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end
    assign p    = p_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed self-checking bench for mul8_seq.
module tb_mul8_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x = 8'h00;
    logic [7:0]  y = 8'h00;
    logic [15:0] p;
    logic        busy;
    logic        done;
    int vectors = 0;
    int miscompares = 0;
`ifdef MUL8_EARLY_EXIT_EN
    localparam int ZLAT = 0;
    localparam int ZBUSY = 1;
`else
    localparam int ZLAT = 8;
    localparam int ZBUSY = 9;
`endif

    mul8_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x(x),
        .y(y),
        .p(p),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start accepted at edge k; returns just after edge k with garbage on x/y.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        x = a;
        y = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        x = ~a;
        y = ~b;
    endtask

    // Samples n cycles starting just after edge k; cycle c is just after edge k+c.
    // If inj >= 0 a stray start (0x11*0x11) is driven so it is sampled at edge k+inj+1.
    task automatic observe(input int n, input int inj, output int done_cyc, output int n_done,
                           output int busy_cyc, output logic [15:0] p_at);
        done_cyc = -1;
        n_done = 0;
        busy_cyc = 0;
        p_at = 16'hxxxx;
        for (int c = 0; c < n; c++) begin
            if (done === 1'b1) begin
                if (done_cyc < 0) begin
                    done_cyc = c;
                    p_at = p;
                end
                n_done++;
            end
            if (busy === 1'b1) busy_cyc++;
            if (c == inj) begin
                start = 1'b1;
                x = 8'h11;
                y = 8'h11;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (p !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: p=%h busy=%b done=%b, want p=0000 busy=0 done=0", p, busy, done);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int lat, input int bcyc);
        int dc, nd, bc;
        logic [15:0] pa;
        pulse_start(a, b);
        observe(12, -1, dc, nd, bc, pa);
        vectors++;
        if (dc !== lat || nd !== 1) begin
            miscompares++;
            $display("FAIL %s_done: first at %0d count %0d, want at %0d count 1", name, dc, nd, lat);
        end
        vectors++;
        if (pa !== exp) begin
            miscompares++;
            $display("FAIL %s_product: p=%h, want %h", name, pa, exp);
        end
        vectors++;
        if (bc !== bcyc) begin
            miscompares++;
            $display("FAIL %s_busy: busy cycles %0d, want %0d", name, bc, bcyc);
        end
    endtask

    task automatic test_products();
        run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 8, 9);
        run_op("0c_0a", 8'h0C, 8'h0A, 16'h0078, 8, 9);
        run_op("80_02", 8'h80, 8'h02, 16'h0100, 8, 9);
        run_op("a5_5a", 8'hA5, 8'h5A, 16'h3A02, 8, 9);
    endtask

    task automatic test_zero_operand();
        run_op("00_55", 8'h00, 8'h55, 16'h0000, ZLAT, ZBUSY);
        run_op("ff_ff_again", 8'hFF, 8'hFF, 16'hFE01, 8, 9);
        run_op("37_00", 8'h37, 8'h00, 16'h0000, ZLAT, ZBUSY);
    endtask

    task automatic test_ignored_start();
        int dc, nd, bc;
        logic [15:0] pa;
        pulse_start(8'h05, 8'h03);
        observe(14, 3, dc, nd, bc, pa);
        vectors++;
        if (dc !== 8 || nd !== 1 || pa !== 16'h000F) begin
            miscompares++;
            $display("FAIL ignored_start: done at %0d count %0d p=%h, want at 8 count 1 p=000F", dc, nd, pa);
        end
        vectors++;
        if (p !== 16'h000F || bc !== 9) begin
            miscompares++;
            $display("FAIL ignored_start_hold: p=%h busy cycles %0d, want p=000F busy 9", p, bc);
        end
    endtask

    task automatic test_abort();
        int dc, nd, bc;
        logic [15:0] pa;
        pulse_start(8'hFF, 8'hFF);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (p !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: p=%h busy=%b done=%b, want p=0000 busy=0 done=0", p, busy, done);
        end
        tick();
        rst_n = 1'b1;
        observe(12, -1, dc, nd, bc, pa);
        vectors++;
        if (nd !== 0 || bc !== 0 || p !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_quiet: done count %0d busy cycles %0d p=%h, want 0 0 0000", nd, bc, p);
        end
        run_op("after_abort", 8'h02, 8'h03, 16'h0006, 8, 9);
    endtask

    task automatic test_back_to_back();
        int dc, nd, bc;
        logic [15:0] pa;
        pulse_start(8'h12, 8'h34);
        observe(9, -1, dc, nd, bc, pa);
        vectors++;
        if (dc !== 8 || pa !== 16'h03A8 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: done at %0d p=%h busy=%b, want at 8 p=03A8 busy=0", dc, pa, busy);
        end
        run_op("b2b_second", 8'h0F, 8'h0E, 16'h00D2, 8, 9);
    endtask

    initial begin
        test_reset();
        test_products();
        test_zero_operand();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
